// File: rtl/fetch_redirect_ctrl_pkg.sv
// Shared pipeline package: control-flow opcodes, funct3 codes, redirect FSM
// encoding and RV64 immediate extraction helpers (all sign-extended to 64 bits).
package fetch_redirect_ctrl_pkg;

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;
  localparam logic [2:0] F3_JALR = 3'b000;

  typedef enum logic [1:0] {
    ST_RESET  = 2'd0,
    ST_WARMUP = 2'd1,
    ST_RUN    = 2'd2,
    ST_FLUSH  = 2'd3
  } fsm_state_t;

  // J-immediate from instruction[31:12]; byte offset, bit 0 always zero.
  function automatic logic [63:0] imm_j(input logic [19:0] hi);
    logic [20:0] raw;
    raw = {hi[19], hi[7:0], hi[8], hi[18:9], 1'b0};
    return {{43{raw[20]}}, raw};
  endfunction

  // B-immediate from instruction[31:25] and instruction[11:7].
  function automatic logic [63:0] imm_b(input logic [6:0] hi, input logic [4:0] lo);
    logic [12:0] raw;
    raw = {hi[6], lo[0], hi[5:0], lo[4:1], 1'b0};
    return {{51{raw[12]}}, raw};
  endfunction

  // I-immediate from instruction[31:20].
  function automatic logic [63:0] imm_i(input logic [11:0] raw);
    return {{52{raw[11]}}, raw};
  endfunction

endpackage

// File: rtl/fetch_redirect_ctrl_branch_compare.sv
// Conditional-branch evaluator: pure combinational compare of the two
// register operands selected by funct3. funct3 010/011 are reserved encodings.
module fetch_redirect_ctrl_branch_compare
  import fetch_redirect_ctrl_pkg::*;
(
  input  logic [63:0] rs1,
  input  logic [63:0] rs2,
  input  logic [2:0]  funct3,
  output logic        taken,
  output logic        illegal
);

  // Evaluate branch condition; reserved encodings never take.
  always_comb begin
    taken   = 1'b0;
    illegal = 1'b0;
    case (funct3)
      F3_BEQ:  taken = (rs1 == rs2);
      F3_BNE:  taken = (rs1 != rs2);
      F3_BLT:  taken = ($signed(rs1) < $signed(rs2));
      F3_BGE:  taken = ($signed(rs1) >= $signed(rs2));
      F3_BLTU: taken = (rs1 < rs2);
      F3_BGEU: taken = (rs1 >= rs2);
      default: begin
        taken   = 1'b0;
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/fetch_redirect_ctrl.sv
// Fetch redirect controller: resolves JAL/JALR/Bxx, squashes wrong-path
// fetches, sequences fetch reset and hands a valid-qualified stream to decode.
// Optional macro BRANCH_STATS_EN adds saturating redirect/squash counters.
module fetch_redirect_ctrl
  import fetch_redirect_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int PC_W         = 64
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic [31:0]     instruction,
  input  logic [PC_W-1:0] pc_current_instruction,
  input  logic [PC_W-1:0] pc_next_instruction,
  output logic [4:0]      rs1_addr,
  output logic [4:0]      rs2_addr,
  input  logic [63:0]     rs1_data,
  input  logic [63:0]     rs2_data,
  output logic            branch,
  output logic [PC_W-1:0] pc_target,
  output logic            reset_pc,
  output logic            dec_valid,
  output logic [31:0]     dec_instruction,
  output logic [PC_W-1:0] dec_pc,
  output logic [PC_W-1:0] dec_link,
  output logic            illegal_cf
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0]     stat_redirects,
  output logic [31:0]     stat_squashed
`endif
);

  localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  fsm_state_t        state_r;
  logic [CNT_W-1:0]  flush_cnt_r;
  logic              cmp_taken_s;
  logic              cmp_illegal_s;
  logic              illegal_dec_s;
  logic [6:0]        opcode_s;
  logic [2:0]        funct3_s;
  logic [63:0]       off_s;
  logic [63:0]       jalr_sum_s;

  assign opcode_s = instruction[6:0];
  assign funct3_s = instruction[14:12];
  assign rs1_addr = instruction[19:15];
  assign rs2_addr = instruction[24:20];

  fetch_redirect_ctrl_branch_compare u_cmp (
    .rs1     (rs1_data),
    .rs2     (rs2_data),
    .funct3  (funct3_s),
    .taken   (cmp_taken_s),
    .illegal (cmp_illegal_s)
  );

  // Redirect resolution; only RUN-state instructions are architectural.
  always_comb begin
    branch        = 1'b0;
    pc_target     = '0;
    illegal_dec_s = 1'b0;
    off_s         = 64'd0;
    jalr_sum_s    = 64'd0;
    if (state_r == ST_RUN) begin
      case (opcode_s)
        OP_JAL: begin
          off_s     = imm_j(instruction[31:12]);
          branch    = 1'b1;
          pc_target = pc_current_instruction + PC_W'({{2{off_s[63]}}, off_s[63:2]});
        end
        OP_JALR: begin
          if (funct3_s == F3_JALR) begin
            jalr_sum_s = (rs1_data + imm_i(instruction[31:20])) & ~64'd1;
            branch     = 1'b1;
            pc_target  = PC_W'({2'b00, jalr_sum_s[63:2]});
          end else begin
            illegal_dec_s = 1'b1;
          end
        end
        OP_BRANCH: begin
          off_s         = imm_b(instruction[31:25], instruction[11:7]);
          illegal_dec_s = cmp_illegal_s;
          if (cmp_taken_s) begin
            branch    = 1'b1;
            pc_target = pc_current_instruction + PC_W'({{2{off_s[63]}}, off_s[63:2]});
          end else begin
            branch = 1'b0;
          end
        end
        default: begin
          branch = 1'b0;
        end
      endcase
    end else begin
      branch = 1'b0;
    end
  end

  // Reset sequencing and squash FSM with registered fetch reset request.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= ST_RESET;
      reset_pc    <= 1'b1;
      flush_cnt_r <= '0;
    end else begin
      reset_pc <= 1'b0;
      case (state_r)
        ST_RESET:  state_r <= ST_WARMUP;
        ST_WARMUP: state_r <= ST_RUN;
        ST_RUN: begin
          if (branch) begin
            state_r     <= ST_FLUSH;
            flush_cnt_r <= CNT_W'(FLUSH_CYCLES - 1);
          end else begin
            state_r <= ST_RUN;
          end
        end
        ST_FLUSH: begin
          if (flush_cnt_r == '0) begin
            state_r <= ST_RUN;
          end else begin
            flush_cnt_r <= flush_cnt_r - CNT_W'(1);
          end
        end
        default: state_r <= ST_RESET;
      endcase
    end
  end

  // Decode handoff: fields captured every edge, qualified by RUN state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      dec_valid       <= 1'b0;
      dec_instruction <= 32'd0;
      dec_pc          <= '0;
      dec_link        <= '0;
      illegal_cf      <= 1'b0;
    end else begin
      dec_valid       <= (state_r == ST_RUN);
      dec_instruction <= instruction;
      dec_pc          <= pc_current_instruction;
      dec_link        <= pc_next_instruction;
      illegal_cf      <= (state_r == ST_RUN) & illegal_dec_s;
    end
  end

`ifdef BRANCH_STATS_EN
  // Saturating counters of redirect cycles and squashed (FLUSH) cycles.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stat_redirects <= 32'd0;
      stat_squashed  <= 32'd0;
    end else begin
      if (branch && (stat_redirects != 32'hFFFF_FFFF)) begin
        stat_redirects <= stat_redirects + 32'd1;
      end else begin
        stat_redirects <= stat_redirects;
      end
      if ((state_r == ST_FLUSH) && (stat_squashed != 32'hFFFF_FFFF)) begin
        stat_squashed <= stat_squashed + 32'd1;
      end else begin
        stat_squashed <= stat_squashed;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Self-checking bench for fetch_redirect_ctrl: the bench plays fetch and the
// register file, pushes expected decode handoff values to a scoreboard queue
// when each instruction is presented and pops them after the capturing edge.
module tb_fetch_redirect_ctrl;

  logic        clock;
  logic        reset_n;
  logic [31:0] instruction;
  logic [63:0] pc_current_instruction;
  logic [63:0] pc_next_instruction;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [63:0] rs1_data;
  logic [63:0] rs2_data;
  logic        branch;
  logic [63:0] pc_target;
  logic        reset_pc;
  logic        dec_valid;
  logic [31:0] dec_instruction;
  logic [63:0] dec_pc;
  logic [63:0] dec_link;
  logic        illegal_cf;
`ifdef BRANCH_STATS_EN
  logic [31:0] stat_redirects;
  logic [31:0] stat_squashed;
`endif

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        v;
    logic [31:0] ins;
    logic [63:0] pc;
    logic [63:0] link;
    logic        ill;
  } exp_t;
  exp_t sb[$];

  localparam logic [31:0] NOP = 32'h0000_0013;

  fetch_redirect_ctrl #(.FLUSH_CYCLES(1), .PC_W(64)) dut (
    .clock                  (clock),
    .reset_n                (reset_n),
    .instruction            (instruction),
    .pc_current_instruction (pc_current_instruction),
    .pc_next_instruction    (pc_next_instruction),
    .rs1_addr               (rs1_addr),
    .rs2_addr               (rs2_addr),
    .rs1_data               (rs1_data),
    .rs2_data               (rs2_data),
    .branch                 (branch),
    .pc_target              (pc_target),
    .reset_pc               (reset_pc),
    .dec_valid              (dec_valid),
    .dec_instruction        (dec_instruction),
    .dec_pc                 (dec_pc),
    .dec_link               (dec_link),
    .illegal_cf             (illegal_cf)
`ifdef BRANCH_STATS_EN
    ,
    .stat_redirects         (stat_redirects),
    .stat_squashed          (stat_squashed)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [2:0] f3,
                                        input logic [4:0] rs1, input logic [4:0] rs2);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_j(input logic [20:0] imm);
    return {imm[20], imm[10:1], imm[11], imm[19:12], 5'd1, 7'b1101111};
  endfunction

  function automatic logic [31:0] enc_jalr(input logic [11:0] imm, input logic [2:0] f3,
                                           input logic [4:0] rs1);
    return {imm, rs1, f3, 5'd1, 7'b1100111};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One fetch slot: present instruction, check redirect, then check handoff.
  task automatic cyc(input logic [31:0] ins, input logic [63:0] pc,
                     input logic [63:0] r1, input logic [63:0] r2,
                     input logic exp_v, input logic exp_br,
                     input logic [63:0] exp_tgt, input logic exp_ill);
    exp_t e;
    @(negedge clock);
    instruction            = ins;
    pc_current_instruction = pc;
    pc_next_instruction    = pc + 64'd1;
    rs1_data               = r1;
    rs2_data               = r2;
    #1;
    checks++;
    if (branch !== exp_br) begin
      errors++;
      $display("FAIL branch@pc=%h: got %b expected %b", pc, branch, exp_br);
    end
    checks++;
    if (pc_target !== exp_tgt) begin
      errors++;
      $display("FAIL pc_target@pc=%h: got %h expected %h", pc, pc_target, exp_tgt);
    end
    checks++;
    if (rs1_addr !== ins[19:15] || rs2_addr !== ins[24:20]) begin
      errors++;
      $display("FAIL rs_addr@pc=%h: got %h/%h expected %h/%h", pc, rs1_addr, rs2_addr,
               ins[19:15], ins[24:20]);
    end
    sb.push_back('{v: exp_v, ins: ins, pc: pc, link: pc + 64'd1, ill: exp_ill});
    @(posedge clock);
    #1;
    e = sb.pop_front();
    checks++;
    if (dec_valid !== e.v) begin
      errors++;
      $display("FAIL dec_valid@pc=%h: got %b expected %b", e.pc, dec_valid, e.v);
    end
    checks++;
    if (dec_instruction !== e.ins || dec_pc !== e.pc || dec_link !== e.link) begin
      errors++;
      $display("FAIL dec_fields@pc=%h: got %h/%h/%h expected %h/%h/%h", e.pc,
               dec_instruction, dec_pc, dec_link, e.ins, e.pc, e.link);
    end
    checks++;
    if (illegal_cf !== e.ill) begin
      errors++;
      $display("FAIL illegal_cf@pc=%h: got %b expected %b", e.pc, illegal_cf, e.ill);
    end
  endtask

  // Release reset and walk RESET -> WARMUP -> RUN up to the first PC-0 handoff.
  task automatic release_and_warmup();
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    chk("reset_pc_before_edge", {63'd0, reset_pc}, 64'd1);
    @(posedge clock);
    #1;
    chk("reset_pc_after_edge", {63'd0, reset_pc}, 64'd0);
    cyc(enc_j(21'd64), 64'd77, 64'd0, 64'd0, 1'b0, 1'b0, 64'd0, 1'b0);
    cyc(NOP, 64'd0, 64'd0, 64'd0, 1'b1, 1'b0, 64'd0, 1'b0);
  endtask

  task automatic test_reset();
    reset_n                = 1'b1;
    instruction            = enc_j(21'd64);
    pc_current_instruction = 64'd0;
    pc_next_instruction    = 64'd1;
    rs1_data               = 64'd0;
    rs2_data               = 64'd0;
    #1;
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_reset_pc", {63'd0, reset_pc}, 64'd1);
    chk("rst_dec_valid", {63'd0, dec_valid}, 64'd0);
    chk("rst_dec_pc", dec_pc, 64'd0);
    chk("rst_illegal_cf", {63'd0, illegal_cf}, 64'd0);
    chk("rst_branch_gated", {63'd0, branch}, 64'd0);
    chk("rst_pc_target", pc_target, 64'd0);
    release_and_warmup();
  endtask

  task automatic test_beq();
    cyc(NOP, 64'd4, 64'd0, 64'd0, 1'b1, 1'b0, 64'd0, 1'b0);
    cyc(enc_b(13'd16, 3'b000, 5'd1, 5'd2), 64'd5, 64'd7, 64'd7, 1'b1, 1'b1, 64'd9, 1'b0);
    cyc(NOP, 64'd6, 64'd0, 64'd0, 1'b0, 1'b0, 64'd0, 1'b0);
    cyc(NOP, 64'd9, 64'd0, 64'd0, 1'b1, 1'b0, 64'd0, 1'b0);
  endtask

  task automatic test_signed_unsigned();
    cyc(enc_b(13'h1FF8, 3'b100, 5'd3, 5'd4), 64'd20, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0,
        1'b1, 1'b1, 64'd18, 1'b0);
    cyc(NOP, 64'd21, 64'd0, 64'd0, 1'b0, 1'b0, 64'd0, 1'b0);
    cyc(enc_b(13'h1FF8, 3'b110, 5'd3, 5'd4), 64'd18, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0,
        1'b1, 1'b0, 64'd0, 1'b0);
    cyc(NOP, 64'd19, 64'd0, 64'd0, 1'b1, 1'b0, 64'd0, 1'b0);
  endtask

  task automatic test_jalr();
    cyc(enc_jalr(12'd0, 3'b000, 5'd5), 64'd3, 64'h103, 64'd0, 1'b1, 1'b1, 64'h40, 1'b0);
    cyc(NOP, 64'd4, 64'd0, 64'd0, 1'b0, 1'b0, 64'd0, 1'b0);
    cyc(NOP, 64'h40, 64'd0, 64'd0, 1'b1, 1'b0, 64'd0, 1'b0);
  endtask

  task automatic test_illegal();
    cyc(enc_b(13'd16, 3'b010, 5'd1, 5'd2), 64'd50, 64'd0, 64'd0, 1'b1, 1'b0, 64'd0, 1'b1);
    cyc(NOP, 64'd51, 64'd0, 64'd0, 1'b1, 1'b0, 64'd0, 1'b0);
    cyc(enc_jalr(12'd8, 3'b001, 5'd5), 64'd52, 64'h100, 64'd0, 1'b1, 1'b0, 64'd0, 1'b1);
    cyc(NOP, 64'd53, 64'd0, 64'd0, 1'b1, 1'b0, 64'd0, 1'b0);
  endtask

  task automatic test_back_to_back();
    cyc(enc_j(21'd40), 64'd30, 64'd0, 64'd0, 1'b1, 1'b1, 64'd40, 1'b0);
    cyc(enc_b(13'd8, 3'b001, 5'd1, 5'd2), 64'd31, 64'd1, 64'd2, 1'b0, 1'b0, 64'd0, 1'b0);
    cyc(NOP, 64'd40, 64'd0, 64'd0, 1'b1, 1'b0, 64'd0, 1'b0);
  endtask

  task automatic test_jal_negative();
    cyc(enc_j(21'h1FFFF4), 64'd100, 64'd0, 64'd0, 1'b1, 1'b1, 64'd97, 1'b0);
    cyc(NOP, 64'd101, 64'd0, 64'd0, 1'b0, 1'b0, 64'd0, 1'b0);
    cyc(NOP, 64'd97, 64'd0, 64'd0, 1'b1, 1'b0, 64'd0, 1'b0);
  endtask

  task automatic test_wrap_and_self();
    cyc(enc_b(13'd4, 3'b000, 5'd1, 5'd2), 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 64'd3,
        1'b1, 1'b1, 64'd0, 1'b0);
    cyc(NOP, 64'd0, 64'd0, 64'd0, 1'b0, 1'b0, 64'd0, 1'b0);
    cyc(enc_b(13'd0, 3'b000, 5'd1, 5'd2), 64'd60, 64'd5, 64'd5, 1'b1, 1'b1, 64'd60, 1'b0);
    cyc(NOP, 64'd61, 64'd0, 64'd0, 1'b0, 1'b0, 64'd0, 1'b0);
    cyc(enc_b(13'd0, 3'b000, 5'd1, 5'd2), 64'd60, 64'd5, 64'd6, 1'b1, 1'b0, 64'd0, 1'b0);
  endtask

  task automatic test_reset_mid_flush();
    cyc(enc_j(21'd8), 64'd10, 64'd0, 64'd0, 1'b1, 1'b1, 64'd12, 1'b0);
    @(negedge clock);
    instruction            = enc_b(13'd8, 3'b001, 5'd1, 5'd2);
    pc_current_instruction = 64'd11;
    pc_next_instruction    = 64'd12;
    rs1_data               = 64'd1;
    rs2_data               = 64'd2;
    #1;
    chk("flush_branch_gated", {63'd0, branch}, 64'd0);
    chk("flush_dec_valid_before_rst", {63'd0, dec_valid}, 64'd1);
    #1;
    reset_n = 1'b0;
    #1;
    chk("midflush_dec_valid", {63'd0, dec_valid}, 64'd0);
    chk("midflush_reset_pc", {63'd0, reset_pc}, 64'd1);
    chk("midflush_dec_pc", dec_pc, 64'd0);
    chk("midflush_branch", {63'd0, branch}, 64'd0);
    release_and_warmup();
    cyc(NOP, 64'd1, 64'd0, 64'd0, 1'b1, 1'b0, 64'd0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_beq();
    test_signed_unsigned();
    test_jalr();
    test_illegal();
    test_back_to_back();
    test_jal_negative();
    test_wrap_and_self();
    test_reset_mid_flush();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
